fm_mod: RTL and testbench
=========================

Name: fm_mod

Overview:
- Digital FM modulator; transmit-side counterpart of fm_demod.
- Accepts a stream of signed baseband samples and drives a phase accumulator (NCO) whose increment is proportional to each sample.
- Produces baseband I/Q through a quarter-wave sine lookup, in the same I/Q format fm_demod consumes. Used for loopback self-test and for the transmit path.

Parameters:
- WIDTH, 10: sample width and I/Q output width, signed two's complement.
- PHASE_W, 16: phase accumulator width. Must satisfy WIDTH+DEV_SHIFT <= PHASE_W.
- ADDR_W, 6: quarter-wave LUT address bits; the LUT has 2^ADDR_W entries.
- DEV_SHIFT, 4: deviation gain. The per-sample phase increment from x_i is sext(x_i) << DEV_SHIFT.
- CENTER_INC, 0: constant phase increment added per sample (carrier offset), PHASE_W bits.

Ports:
- clk  input  1  system clock; the block has one clock.
- rst_i  input  1  synchronous, active-high reset.
- clken_i  input  1  pipeline enable; when low, every register holds.
- x_i  input  WIDTH  signed modulating sample.
- dvalid_i  input  1  x_i valid this cycle.
- I_o  output  WIDTH  signed in-phase output, cos(phase).
- Q_o  output  WIDTH  signed quadrature output, sin(phase).
- dvalid_o  output  1  I_o/Q_o valid this cycle.

Behaviour:
- Reset (rst_i=1 at a clk edge):
  - phase, all pipeline registers, I_o, Q_o and dvalid_o are cleared to 0.
  - Reset is not gated by clken_i.
  - In-flight samples are discarded.
- Sample acceptance: a sample is accepted at an edge where clken_i=1 and dvalid_i=1. No backpressure; the block always accepts.
- Stage 1, accumulate: phase <= phase + CENTER_INC + (sext(x_i) << DEV_SHIFT), modulo 2^PHASE_W.
  - Wraps silently.
  - phase holds when no sample is accepted.
  - The registered phase is the one used for lookup, so the first sample after reset with zero increment looks up phase 0.
- Stage 2, address:
  - quadrant qs = phase[PHASE_W-1:PHASE_W-2]; a = phase[PHASE_W-3 -: ADDR_W]; lower bits are truncated.
  - Sine path: address = qs[0] ? ~a : a; negate = qs[1].
  - Cosine path: qc = qs+1 (mod 4); address = qc[0] ? ~a : a; negate = qc[1].
- Stage 3, LUT read (registered) for both paths.
  - LUT[k] = round((2^(WIDTH-1)-1) * sin(pi/2 * (k+0.5)/2^ADDR_W)).
  - The half-step offset makes mirroring exact. Entries are never 0 and never exceed 2^(WIDTH-1)-1, so negation cannot overflow.
- Stage 4, sign and output register: Q_o = negate_s ? -sin_mag : sin_mag; I_o likewise from the cosine path.
- Latency:
  - A sample accepted at the edge ending cycle N gives I_o/Q_o/dvalid_o=1 during cycle N+4.
  - Throughput is one sample per clk.
- Valid tracking:
  - A valid bit travels with each stage.
  - A cycle with clken_i=1 and dvalid_i=0 inserts a bubble: dvalid_o=0 four cycles later, and I_o/Q_o hold their last valid values.
- Enable: while clken_i=0 the whole pipeline freezes, including dvalid_o, I_o and Q_o. No sample is lost or duplicated when clken_i returns high.
- Simultaneous rst_i=1 and dvalid_i=1: reset wins and the sample is dropped.
- Output amplitude is bounded to +/-(2^(WIDTH-1)-1); -2^(WIDTH-1) is never produced.
- Default LUT reference values (WIDTH=10, ADDR_W=6): LUT[0]=6, LUT[1]=19, LUT[63]=511.

Test Plan:
- Reset: hold rst_i=1 for 3 cycles with dvalid_i=1, x_i=100 -> I_o=0, Q_o=0, dvalid_o=0 throughout; after release the first output corresponds to a sample accepted post-reset.
- Zero input: defaults, x_i=0 continuously from cycle 0 -> dvalid_o rises in cycle 4; I_o=511, Q_o=6 constant, with no wander over 10000 samples.
- Positive deviation: x_i=+1 continuously (increment 16, 256 phase counts per LUT step):
  - First outputs I=511, Q=6.
  - Q_o first becomes 19 on the 16th valid output.
  - The I/Q sequence repeats exactly every 4096 valid outputs.
  - sin^2+cos^2 stays within +/-2% of 511^2.
- Negative deviation: x_i=-1 -> first output I_o=511, Q_o=-6; the rotation sense is opposite to the +1 case.
- Gaps and enable:
  - Alternate dvalid_i 1/0 -> dvalid_o alternates with the same pattern, offset by 4 cycles.
  - Drop clken_i for 5 cycles mid-stream -> outputs frozen, then the output sequence continues identical to the no-stall reference model.
- Reset mid-stream: assert rst_i for 1 cycle with 4 samples in flight -> dvalid_o=0 from the next cycle until 4 cycles after the next accepted sample; phase restarts at 0, so x_i=0 gives I_o=511, Q_o=6.

Source files
------------

// File: rtl/fm_mod_if.sv
// fm_mod_if: sample-in / I-Q-out bundle of the FM modulator
interface fm_mod_if #(parameter int WIDTH = 10);
   logic clken_i, dvalid_i, dvalid_o;
   logic signed [WIDTH-1:0] x_i, I_o, Q_o;
   modport master (output clken_i, x_i, dvalid_i, input I_o, Q_o, dvalid_o);
   modport slave (input clken_i, x_i, dvalid_i, output I_o, Q_o, dvalid_o);
endinterface

// File: rtl/fm_mod.sv
// fm_mod: FM modulator, sample-driven NCO with quarter-wave sine LUT producing I/Q
module fm_mod #(
   parameter int WIDTH = 10,
   parameter int PHASE_W = 16,
   parameter int ADDR_W = 6,
   parameter int DEV_SHIFT = 4,
   parameter logic [PHASE_W-1:0] CENTER_INC = '0
) (
   input logic clk,
   input logic rst_i,
   fm_mod_if.slave bus
);
   localparam int N = 2 ** ADDR_W;
   localparam int M = WIDTH - 1;
   logic [M-1:0] lut [N];
   // half-step sample points make ~k the exact mirror of k
   for (genvar g = 0; g < N; g++) begin : g_lut
      localparam real T = 1.5707963267948966 * (real'(g) + 0.5) / real'(N);
      localparam real T2 = T * T;
      localparam real S = T * (1.0 - T2 / 6.0 * (1.0 - T2 / 20.0 * (1.0 - T2 / 42.0 *
                          (1.0 - T2 / 72.0 * (1.0 - T2 / 110.0 * (1.0 - T2 / 156.0))))));
      localparam int V = $rtoi(real'(2 ** M - 1) * S + 0.5);
      assign lut[g] = V[M-1:0];
   end
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [ADDR_W-1:0] sa_q, sa_d, ca_q, ca_d, a;
   logic [M-1:0] sm_q, sm_d, cm_q, cm_d;
   logic [WIDTH-1:0] i_q, i_d, q_q, q_d;
   logic [1:0] ng_q, ng_d, ng3_q, ng3_d, qs, qc;
   logic [3:0] v_q, v_d;
   always_comb begin
      qs = phase_q[PHASE_W-1 -: 2];
      qc = qs + 2'd1;
      a = phase_q[PHASE_W-3 -: ADDR_W];
      phase_d = bus.dvalid_i ? phase_q + CENTER_INC + (PHASE_W'(bus.x_i) << DEV_SHIFT) : phase_q;
      sa_d = qs[0] ? ~a : a;
      ca_d = qc[0] ? ~a : a;
      ng_d = {qs[1], qc[1]};
      sm_d = lut[sa_q];
      cm_d = lut[ca_q];
      ng3_d = ng_q;
      q_d = v_q[2] ? (ng3_q[1] ? -WIDTH'({1'b0, sm_q}) : WIDTH'({1'b0, sm_q})) : q_q;
      i_d = v_q[2] ? (ng3_q[0] ? -WIDTH'({1'b0, cm_q}) : WIDTH'({1'b0, cm_q})) : i_q;
      v_d = {v_q[2:0], bus.dvalid_i};
   end
   always_ff @(posedge clk) begin
      if (rst_i) begin
         phase_q <= '0;
         sa_q <= '0;
         ca_q <= '0;
         ng_q <= '0;
         sm_q <= '0;
         cm_q <= '0;
         ng3_q <= '0;
         i_q <= '0;
         q_q <= '0;
         v_q <= '0;
      end else if (bus.clken_i) begin
         phase_q <= phase_d;
         sa_q <= sa_d;
         ca_q <= ca_d;
         ng_q <= ng_d;
         sm_q <= sm_d;
         cm_q <= cm_d;
         ng3_q <= ng3_d;
         i_q <= i_d;
         q_q <= q_d;
         v_q <= v_d;
      end
   end
   assign bus.I_o = i_q;
   assign bus.Q_o = q_q;
   assign bus.dvalid_o = v_q[3];
endmodule

// File: tb/tb_fm_mod.sv
// tb_fm_mod: directed vectors plus a sin()-based scoreboard for fm_mod
module tb_fm_mod;
   localparam int W = 10;
   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;
   fm_mod_if #(.WIDTH(W)) bus ();
   fm_mod dut (.clk(clk), .rst_i(rst_i), .bus(bus));

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lutv(input int k);
      return $rtoi(511.0 * $sin(3.141592653589793 * (real'(k) + 0.5) / 128.0) + 0.5);
   endfunction
   function automatic void expv(input logic [15:0] p, output int ei, output int eq);
      logic [1:0] qs, qc;
      int a;
      qs = p[15:14];
      qc = qs + 2'd1;
      a = int'(p[13:8]);
      eq = lutv(qs[0] ? 63 - a : a);
      ei = lutv(qc[0] ? 63 - a : a);
      if (qs[1]) eq = -eq;
      if (qc[1]) ei = -ei;
   endfunction

   logic [15:0] mphase;
   int qi[$], qq[$];
   int mode = 0, last_i, last_q, prev_dv = 0;
   bit have_last = 0;
   initial begin
      int ei, eq, d;
      forever begin
         @(posedge clk);
         if (rst_i) begin
            mphase = '0;
            qi.delete();
            qq.delete();
            have_last = 0;
            mode = 0;
         end else begin
            mode = bus.clken_i ? 1 : 2;
            if (bus.clken_i && bus.dvalid_i) begin
               d = int'(bus.x_i) * 16;
               mphase = mphase + 16'(d);
               expv(mphase, ei, eq);
               qi.push_back(ei);
               qq.push_back(eq);
            end
         end
         @(negedge clk);
         if (mode == 1 && bus.dvalid_o) begin
            chk("sb_avail", int'(qi.size() > 0), 1);
            if (qi.size() > 0) begin
               last_i = qi.pop_front();
               last_q = qq.pop_front();
               have_last = 1;
               chk("sb_I", int'(bus.I_o), last_i);
               chk("sb_Q", int'(bus.Q_o), last_q);
            end
         end else if (mode != 0) begin
            if (mode == 2) chk("freeze_dv", int'(bus.dvalid_o), prev_dv);
            if (have_last) begin
               chk("hold_I", int'(bus.I_o), last_i);
               chk("hold_Q", int'(bus.Q_o), last_q);
            end
         end
         prev_dv = int'(bus.dvalid_o);
      end
   end

   typedef struct {int x; int ei; int eq;} vec_t;
   vec_t tbl[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input bit en, input bit dv, input int x);
      bus.clken_i = en;
      bus.dvalid_i = dv;
      bus.x_i = W'(x);
   endtask
   task automatic do_reset();
      rst_i = 1'b1;
      drive(1, 0, 0);
      tick();
      rst_i = 1'b0;
   endtask
   task automatic chk_out(input string name, input int dv, input int ei, input int eq);
      chk({name, "_dv"}, int'(bus.dvalid_o), dv);
      chk({name, "_I"}, int'(bus.I_o), ei);
      chk({name, "_Q"}, int'(bus.Q_o), eq);
   endtask

   initial begin
      int k, first19, bad, nout, r, minr, maxr;
      int si[4096], sq[4096];
      bit en_last;
      tbl[0] = '{0, 511, 6};
      tbl[1] = '{256, 470, 201};
      tbl[2] = '{256, 357, 366};
      tbl[3] = '{256, 190, 474};
      tbl[4] = '{256, -6, 511};
      tbl[5] = '{256, -201, 470};
      tbl[6] = '{256, -366, 357};
      tbl[7] = '{256, -474, 190};
      tbl[8] = '{256, -511, -6};
      tbl[9] = '{256, -470, -201};
      tbl[10] = '{256, -357, -366};
      tbl[11] = '{256, -190, -474};
      tbl[12] = '{256, 6, -511};
      tbl[13] = '{-512, -357, -366};
      tbl[14] = '{511, -6, -511};

      rst_i = 1'b1;
      drive(1, 1, 100);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_out("reset", 0, 0, 0);
      end
      rst_i = 1'b0;
      drive(1, 0, 0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("idle_dv", int'(bus.dvalid_o), 0);
      end
      drive(1, 1, 0);
      for (int j = 1; j <= 4; j++) begin
         tick();
         drive(1, 0, 0);
         chk("first_lat_dv", int'(bus.dvalid_o), int'(j == 4));
      end
      chk("first_I", int'(bus.I_o), 511);
      chk("first_Q", int'(bus.Q_o), 6);

      do_reset();
      for (int c = 0; c < 18; c++) begin
         if (c < 15) drive(1, 1, tbl[c].x);
         else drive(1, 0, 0);
         tick();
         if (c >= 3) chk_out($sformatf("tbl%0d", c - 3), 1, tbl[c-3].ei, tbl[c-3].eq);
      end

      do_reset();
      drive(1, 1, 0);
      bad = 0;
      for (int c = 1; c <= 10004; c++) begin
         tick();
         if (c <= 4) chk("zero_lat_dv", int'(bus.dvalid_o), int'(c == 4));
         if (c >= 4 && (bus.dvalid_o !== 1'b1 || int'(bus.I_o) != 511 || int'(bus.Q_o) != 6)) bad++;
      end
      chk("zero_wander", bad, 0);

      do_reset();
      drive(1, 1, 1);
      k = 0;
      first19 = -1;
      bad = 0;
      minr = 1 << 30;
      maxr = 0;
      for (int c = 0; c < 8300 && k < 8192; c++) begin
         tick();
         if (bus.dvalid_o) begin
            k++;
            if (k == 1) begin
               chk("pos_first_I", int'(bus.I_o), 511);
               chk("pos_first_Q", int'(bus.Q_o), 6);
            end
            if (first19 < 0 && int'(bus.Q_o) == 19) first19 = k;
            if (k <= 4096) begin
               si[k-1] = int'(bus.I_o);
               sq[k-1] = int'(bus.Q_o);
            end else if (si[k-4097] != int'(bus.I_o) || sq[k-4097] != int'(bus.Q_o)) bad++;
            r = int'(bus.I_o) * int'(bus.I_o) + int'(bus.Q_o) * int'(bus.Q_o);
            if (r < minr) minr = r;
            if (r > maxr) maxr = r;
         end
      end
      chk("pos_count", k, 8192);
      chk("pos_first19", first19, 16);
      chk("pos_period", bad, 0);
      chk("pos_rmin_ok", int'(minr >= 255899), 1);
      chk("pos_rmax_ok", int'(maxr <= 266343), 1);

      do_reset();
      drive(1, 1, -1);
      k = 0;
      for (int c = 0; c < 22; c++) begin
         tick();
         if (bus.dvalid_o) begin
            k++;
            if (k == 1) begin
               chk("neg_first_I", int'(bus.I_o), 511);
               chk("neg_first_Q", int'(bus.Q_o), -6);
            end
            if (k == 16) chk("neg16_Q", int'(bus.Q_o), -6);
            if (k == 17) chk("neg17_Q", int'(bus.Q_o), -19);
         end
      end

      do_reset();
      for (int t = 0; t < 24; t++) begin
         drive(1, t % 2 == 0 && t < 16, 256);
         tick();
         chk("gap_dv", int'(bus.dvalid_o), int'(t >= 3 && (t - 3) % 2 == 0 && t - 3 < 16));
      end

      do_reset();
      nout = 0;
      en_last = 1'b1;
      for (int c = 0; c < 32; c++) begin
         en_last = !(c >= 8 && c < 13);
         drive(en_last, c < 20, 256);
         tick();
         if (bus.dvalid_o && en_last) nout++;
      end
      chk("stall_count", nout, 15);
      chk("stall_sb_empty", qi.size(), 0);

      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(1, 1, 256);
         tick();
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk_out("midrst", 0, 0, 0);
      drive(1, 0, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("midrst_idle_dv", int'(bus.dvalid_o), 0);
      end
      drive(1, 1, 0);
      for (int j = 1; j <= 4; j++) begin
         tick();
         drive(1, 0, 0);
         chk("midrst_lat_dv", int'(bus.dvalid_o), int'(j == 4));
      end
      chk("midrst_I", int'(bus.I_o), 511);
      chk("midrst_Q", int'(bus.Q_o), 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
